ram_bus_param: RTL and testbench

Parametrised, byte-addressed 32-bit-data RAM for the MIPS testbench bus, replacing the fixed 8x8192 model. Maps up to four configurable 32-bit address regions onto one contiguous physical array. Adds configurable wait states (waitrequest), pipelined read latency with readdatavalid, byte-enable-qualified writes and an unmapped-access error flag. Sits between the CPU bus port and simulated memory; instruction and data instances are separate.

---
 rtl/ram_bus_param.sv | 245 ++++++++++++++++++++++++
 tb/tb_ram_bus_param.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_param.sv
// ram_bus_param: byte-addressed 32-bit RAM for the MIPS testbench bus.
// Four address regions map onto one contiguous physical byte array.
// Configurable wait states (waitrequest), pipelined read latency with
// readdatavalid, byte-enable writes and a one-cycle error pulse.
// err is registered and is high in the cycle after the accepting cycle.
// Optional feature: define RAM_RANDOM_STALL_EN to add 0..3 LFSR-driven
// extra stall cycles per request.
module ram_bus_param #(
  parameter string       RAM_INIT_FILE = "",
  parameter int          DEPTH_BYTES   = 8192,
  parameter logic [31:0] R0_BASE       = 32'h0000_0000,
  parameter logic [31:0] R0_SIZE       = 32'h0000_0400,
  parameter logic [31:0] R1_BASE       = 32'h8000_0000,
  parameter logic [31:0] R1_SIZE       = 32'h0000_1000,
  parameter logic [31:0] R2_BASE       = 32'hBFC0_0000,
  parameter logic [31:0] R2_SIZE       = 32'h0000_0800,
  parameter logic [31:0] R3_BASE       = 32'hFFFF_FC00,
  parameter logic [31:0] R3_SIZE       = 32'h0000_0400,
  parameter int          WAIT_CYCLES   = 0,
  parameter int          READ_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        err
);

  localparam int          IDX_W  = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [31:0] R1_OFF = R0_SIZE;
  localparam logic [31:0] R2_OFF = R0_SIZE + R1_SIZE;
  localparam logic [31:0] R3_OFF = R0_SIZE + R1_SIZE + R2_SIZE;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } state_e;

  // Elaboration-time configuration checks
  if (32'(DEPTH_BYTES) != (R0_SIZE + R1_SIZE + R2_SIZE + R3_SIZE)) begin : g_err_depth
    $error("ram_bus_param: DEPTH_BYTES must equal R0_SIZE+R1_SIZE+R2_SIZE+R3_SIZE");
  end
  if ((R0_SIZE[1:0] | R1_SIZE[1:0] | R2_SIZE[1:0] | R3_SIZE[1:0]) != 2'b00) begin : g_err_align
    $error("ram_bus_param: region sizes must be multiples of 4 bytes");
  end
  if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_err_wait
    $error("ram_bus_param: WAIT_CYCLES must be in 0..15");
  end
  if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_err_lat
    $error("ram_bus_param: READ_LATENCY must be in 1..4");
  end
  if (RAM_INIT_FILE != "") begin : g_init_note
    $info("ram_bus_param: RAM_INIT_FILE=%s", RAM_INIT_FILE);
  end

  // Region hit test: base <= a <= base+size-1 without 32-bit overflow
  function automatic logic in_region(input logic [31:0] a,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [31:0] rel;
    rel = a - base;
    return (a >= base) && (rel < size);
  endfunction

  logic [7:0]        mem_q [DEPTH_BYTES];
  logic [31:0]       addr_s;
  logic              req_s;
  logic              hit_s;
  logic [IDX_W-1:0]  idx_s;
  logic [31:0]       rd_word_s;
  logic              accept_s;
  logic              wait_s;
  logic              rd_acc_s;
  logic              wr_acc_s;
  logic [4:0]        stall_len_s;
  state_e            state_q;
  logic [4:0]        cnt_q;
  logic [4:0]        tgt_q;
  logic [READ_LATENCY-1:0] vld_q;
  logic [31:0]       dat_q [READ_LATENCY];
  logic              err_q;

  // Word-align the address; the low two bits never select a byte
  assign addr_s = address & 32'hFFFF_FFFC;
  assign req_s  = read | write;

`ifdef RAM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  // Stall-randomising LFSR, stepped each time a new request is sized
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else if ((state_q == S_IDLE) && req_s) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end else begin
      lfsr_q <= lfsr_q;
    end
  end

  assign stall_len_s = 5'(WAIT_CYCLES) + {3'b000, lfsr_q[1:0]};
`else
  assign stall_len_s = 5'(WAIT_CYCLES);
`endif

  // Region decode: first matching region wins, R0 has highest priority
  always_comb begin
    hit_s = 1'b0;
    idx_s = '0;
    if (in_region(addr_s, R0_BASE, R0_SIZE)) begin
      hit_s = 1'b1;
      idx_s = IDX_W'(addr_s - R0_BASE);
    end else if (in_region(addr_s, R1_BASE, R1_SIZE)) begin
      hit_s = 1'b1;
      idx_s = IDX_W'(R1_OFF + (addr_s - R1_BASE));
    end else if (in_region(addr_s, R2_BASE, R2_SIZE)) begin
      hit_s = 1'b1;
      idx_s = IDX_W'(R2_OFF + (addr_s - R2_BASE));
    end else if (in_region(addr_s, R3_BASE, R3_SIZE)) begin
      hit_s = 1'b1;
      idx_s = IDX_W'(R3_OFF + (addr_s - R3_BASE));
    end else begin
      hit_s = 1'b0;
      idx_s = '0;
    end
  end

  // Read word assembly: disabled lanes and unmapped addresses read zero
  always_comb begin
    rd_word_s = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (hit_s && byteenable[i]) begin
        rd_word_s[8*i +: 8] = mem_q[idx_s + IDX_W'(i)];
      end else begin
        rd_word_s[8*i +: 8] = 8'h00;
      end
    end
  end

  // Handshake: decide stall vs accept from FSM state and stall counter
  always_comb begin
    accept_s = 1'b0;
    wait_s   = 1'b1;
    if (!rst_n) begin
      accept_s = 1'b0;
      wait_s   = 1'b1;
    end else if (!req_s) begin
      accept_s = 1'b0;
      wait_s   = 1'b0;
    end else if (state_q == S_IDLE) begin
      accept_s = (stall_len_s == 5'd0);
      wait_s   = (stall_len_s != 5'd0);
    end else if (cnt_q >= tgt_q) begin
      accept_s = 1'b1;
      wait_s   = 1'b0;
    end else begin
      accept_s = 1'b0;
      wait_s   = 1'b1;
    end
  end

  assign rd_acc_s = accept_s & read & ~write;
  assign wr_acc_s = accept_s & write & hit_s;

  // IDLE/STALL FSM with stall counter; dropping req mid-stall abandons it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      tgt_q   <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_s && (stall_len_s != 5'd0)) begin
            state_q <= S_STALL;
            cnt_q   <= 5'd1;
            tgt_q   <= stall_len_s;
          end else begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
          end
        end
        S_STALL: begin
          if (!req_s || (cnt_q >= tgt_q)) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
          end else begin
            cnt_q   <= cnt_q + 5'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 5'd0;
        end
      endcase
    end
  end

  // Byte-lane write port; memory is deliberately not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_acc_s && byteenable[i]) begin
        mem_q[idx_s + IDX_W'(i)] <= writedata[8*i +: 8];
      end
    end
  end

  // Read latency pipeline; reset discards every read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        dat_q[k] <= 32'h0000_0000;
      end
    end else begin
      vld_q[0] <= rd_acc_s;
      dat_q[0] <= rd_acc_s ? rd_word_s : 32'h0000_0000;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        dat_q[k] <= dat_q[k-1];
      end
    end
  end

  // Error pulse for unmapped accesses and simultaneous read+write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept_s & (~hit_s | (read & write));
    end
  end

  assign waitrequest   = wait_s;
  assign readdata      = dat_q[READ_LATENCY-1];
  assign readdatavalid = vld_q[READ_LATENCY-1];
  assign err           = err_q;

endmodule

// File: tb/tb_ram_bus_param.sv
// Bench for ram_bus_param: three instances (default, WAIT=3/LAT=2,
// LAT=4) driven by per-scenario tasks and checked against a byte-level
// reference memory computed from the region map.
module tb_ram_bus_param;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd [ND];
  logic        wr [ND];
  logic [31:0] ad [ND];
  logic [3:0]  be [ND];
  logic [31:0] wd [ND];
  logic        wrq [ND];
  logic [31:0] rdat [ND];
  logic        rv [ND];
  logic        er [ND];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  mref [int];
  logic [31:0] rbase [4] = '{32'h0000_0000, 32'h8000_0000, 32'hBFC0_0000, 32'hFFFF_FC00};
  logic [31:0] rsize [4] = '{32'h0000_0400, 32'h0000_1000, 32'h0000_0800, 32'h0000_0400};

  int          exp_cyc [ND][$];
  logic [31:0] exp_dat [ND][$];
  int          exp_err [ND][$];
  int          got_cyc [ND][$];
  logic [31:0] got_dat [ND][$];
  int          got_err [ND][$];

  ram_bus_param u_d0 (
    .clk(clk), .rst_n(rst_n), .read(rd[0]), .write(wr[0]), .address(ad[0]),
    .byteenable(be[0]), .writedata(wd[0]), .waitrequest(wrq[0]),
    .readdata(rdat[0]), .readdatavalid(rv[0]), .err(er[0]));

  ram_bus_param #(.WAIT_CYCLES(3), .READ_LATENCY(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .read(rd[1]), .write(wr[1]), .address(ad[1]),
    .byteenable(be[1]), .writedata(wd[1]), .waitrequest(wrq[1]),
    .readdata(rdat[1]), .readdatavalid(rv[1]), .err(er[1]));

  ram_bus_param #(.WAIT_CYCLES(0), .READ_LATENCY(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .read(rd[2]), .write(wr[2]), .address(ad[2]),
    .byteenable(be[2]), .writedata(wd[2]), .waitrequest(wrq[2]),
    .readdata(rdat[2]), .readdatavalid(rv[2]), .err(er[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every observed readdatavalid / err pulse with its cycle number
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rv[d] === 1'b1) begin
        got_cyc[d].push_back(cyc);
        got_dat[d].push_back(rdat[d]);
      end
      if (er[d] === 1'b1) got_err[d].push_back(cyc);
    end
  end

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  // Physical byte index of an address, or -1 when no region claims it
  function automatic int phys(input logic [31:0] a);
    logic [31:0] w;
    int off;
    w = a & 32'hFFFF_FFFC;
    off = 0;
    for (int r = 0; r < 4; r++) begin
      if (w >= rbase[r] && w <= rbase[r] + rsize[r] - 32'd1) return off + int'(w - rbase[r]);
      off += int'(rsize[r]);
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a, input logic [3:0] b);
    logic [31:0] res;
    int p;
    res = 32'h0;
    p = phys(a);
    if (p >= 0) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i] && mref.exists(d * 65536 + p + i)) res[8*i +: 8] = mref[d * 65536 + p + i];
      end
    end
    return res;
  endfunction

  function automatic void model_write(input int d, input logic [31:0] a, input logic [3:0] b,
                                      input logic [31:0] data);
    int p;
    p = phys(a);
    if (p >= 0) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) mref[d * 65536 + p + i] = data[8*i +: 8];
      end
    end
  endfunction

  // Issue one request, wait (bounded) for acceptance, update the model
  task automatic do_op(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] data, output int stalls);
    int acc;
    rd[d] = r; wr[d] = w; ad[d] = a; be[d] = b; wd[d] = data;
    stalls = 0;
    acc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wrq[d] === 1'b0) begin
        acc = cyc;
        break;
      end
      stalls++;
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: waitrequest still high after 40 cycles, required accept", d);
    end else begin
      if ((r && w) || phys(a) < 0) exp_err[d].push_back(acc + 1);
      if (w) model_write(d, a, b, data);
      else if (r) begin
        exp_cyc[d].push_back(acc + lat_of(d));
        exp_dat[d].push_back(model_read(d, a, b));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    for (int d = 0; d < ND; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0;
    end
  endtask

  task automatic settle();
    idle_all();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic clear_q(input int d);
    exp_cyc[d].delete(); exp_dat[d].delete(); exp_err[d].delete();
    got_cyc[d].delete(); got_dat[d].delete(); got_err[d].delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    for (int d = 0; d < ND; d++) begin
      ad[d] = 32'h0; be[d] = 4'h0; wd[d] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (wrq[d] !== 1'b1 || rv[d] !== 1'b0 || er[d] !== 1'b0 || rdat[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d got wrq=%b rv=%b err=%b rdata=%h required 1 0 0 00000000",
                 d, wrq[d], rv[d], er[d], rdat[d]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (wrq[d] !== 1'b0) begin
        errors++;
        $display("FAIL idle_wrq dut%0d got %b required 0", d, wrq[d]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int st;
    do_op(0, 1'b0, 1'b1, 32'hBFC0_0000, 4'hF, 32'hDEADBEEF, st);
    do_op(0, 1'b1, 1'b0, 32'hBFC0_0000, 4'hF, 32'h0, st);
    do_op(0, 1'b0, 1'b1, 32'h8000_0010, 4'hF, 32'h11223344, st);
    do_op(0, 1'b0, 1'b1, 32'h8000_0010, 4'b0101, 32'hAABBCCDD, st);
    do_op(0, 1'b1, 1'b0, 32'h8000_0013, 4'hF, 32'h0, st);
    do_op(0, 1'b1, 1'b0, 32'h8000_0010, 4'b0011, 32'h0, st);
    do_op(0, 1'b1, 1'b1, 32'h8000_0020, 4'hF, 32'hCAFE0001, st);
    do_op(0, 1'b1, 1'b0, 32'h8000_0020, 4'hF, 32'h0, st);
    checks++;
    if (exp_dat[0].size() != 4 || exp_dat[0][0] !== 32'hDEADBEEF || exp_dat[0][1] !== 32'h11BB33DD ||
        exp_dat[0][2] !== 32'h000033DD) begin
      errors++;
      $display("FAIL basic_model_plan got %0d reads, required DEADBEEF 11BB33DD 000033DD", exp_dat[0].size());
    end
    settle();
    checks++;
    if (got_cyc[0].size() != exp_cyc[0].size() || got_err[0].size() != exp_err[0].size()) begin
      errors++;
      $display("FAIL basic_counts got rv=%0d err=%0d required rv=%0d err=%0d",
               got_cyc[0].size(), got_err[0].size(), exp_cyc[0].size(), exp_err[0].size());
    end
    for (int i = 0; i < exp_cyc[0].size() && i < got_cyc[0].size(); i++) begin
      checks++;
      if (got_cyc[0][i] !== exp_cyc[0][i] || got_dat[0][i] !== exp_dat[0][i]) begin
        errors++;
        $display("FAIL basic_read%0d got cyc=%0d data=%h required cyc=%0d data=%h",
                 i, got_cyc[0][i], got_dat[0][i], exp_cyc[0][i], exp_dat[0][i]);
      end
    end
    for (int i = 0; i < exp_err[0].size() && i < got_err[0].size(); i++) begin
      checks++;
      if (got_err[0][i] !== exp_err[0][i]) begin
        errors++;
        $display("FAIL basic_err%0d got cyc=%0d required cyc=%0d", i, got_err[0][i], exp_err[0][i]);
      end
    end
    clear_q(0);
  endtask

  task automatic test_wait_states();
    int st;
    int sts [3];
    do_op(1, 1'b0, 1'b1, 32'h8000_0040, 4'hF, 32'h5A5A_1234, st);
    sts[0] = st;
    do_op(1, 1'b1, 1'b0, 32'h8000_0040, 4'hF, 32'h0, st);
    sts[1] = st;
    do_op(1, 1'b1, 1'b0, 32'h8000_0040, 4'b1100, 32'h0, st);
    sts[2] = st;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sts[i] !== 3) begin
        errors++;
        $display("FAIL wait_stall%0d got %0d stall cycles required 3", i, sts[i]);
      end
    end
    // Abandon a request mid-stall: the next one must stall the full count
    idle_all();
    rd[1] = 1'b1; ad[1] = 32'h8000_0040; be[1] = 4'hF;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (wrq[1] !== 1'b1) begin
        errors++;
        $display("FAIL wait_drop_wrq got %b required 1", wrq[1]);
      end
      @(posedge clk); #1;
    end
    rd[1] = 1'b0;
    @(posedge clk); #1;
    do_op(1, 1'b1, 1'b0, 32'h8000_0040, 4'hF, 32'h0, st);
    checks++;
    if (st !== 3) begin
      errors++;
      $display("FAIL wait_after_drop got %0d stall cycles required 3", st);
    end
    settle();
    checks++;
    if (got_cyc[1].size() != exp_cyc[1].size() || got_err[1].size() != 0) begin
      errors++;
      $display("FAIL wait_counts got rv=%0d err=%0d required rv=%0d err=0",
               got_cyc[1].size(), got_err[1].size(), exp_cyc[1].size());
    end
    for (int i = 0; i < exp_cyc[1].size() && i < got_cyc[1].size(); i++) begin
      checks++;
      if (got_cyc[1][i] !== exp_cyc[1][i] || got_dat[1][i] !== exp_dat[1][i]) begin
        errors++;
        $display("FAIL wait_read%0d got cyc=%0d data=%h required cyc=%0d data=%h",
                 i, got_cyc[1][i], got_dat[1][i], exp_cyc[1][i], exp_dat[1][i]);
      end
    end
    clear_q(1);
  endtask

  task automatic test_pipeline();
    int st;
    for (int i = 0; i < 4; i++) do_op(2, 1'b0, 1'b1, 32'(4 * i), 4'hF, $urandom, st);
    for (int i = 0; i < 4; i++) do_op(2, 1'b1, 1'b0, 32'(4 * i), 4'hF, 32'h0, st);
    settle();
    checks++;
    if (got_cyc[2].size() != 4) begin
      errors++;
      $display("FAIL pipe_count got %0d pulses required 4", got_cyc[2].size());
    end
    for (int i = 0; i < exp_cyc[2].size() && i < got_cyc[2].size(); i++) begin
      checks++;
      if (got_cyc[2][i] !== exp_cyc[2][i] || got_dat[2][i] !== exp_dat[2][i]) begin
        errors++;
        $display("FAIL pipe_read%0d got cyc=%0d data=%h required cyc=%0d data=%h",
                 i, got_cyc[2][i], got_dat[2][i], exp_cyc[2][i], exp_dat[2][i]);
      end
    end
    clear_q(2);
  endtask

  task automatic test_unmapped();
    int st;
    do_op(0, 1'b1, 1'b0, 32'h4000_0000, 4'hF, 32'h0, st);
    do_op(0, 1'b0, 1'b1, 32'h4000_0000, 4'hF, 32'h0BAD_F00D, st);
    do_op(0, 1'b0, 1'b1, 32'h7FFF_FFFC, 4'hF, 32'h0BAD_F00D, st);
    do_op(0, 1'b1, 1'b0, 32'hBFC0_0000, 4'hF, 32'h0, st);
    do_op(0, 1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'h0, st);
    do_op(0, 1'b1, 1'b0, 32'h8000_0020, 4'hF, 32'h0, st);
    do_op(0, 1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0, st);
    settle();
    checks++;
    if (got_cyc[0].size() != exp_cyc[0].size() || got_err[0].size() != exp_err[0].size()) begin
      errors++;
      $display("FAIL unmap_counts got rv=%0d err=%0d required rv=%0d err=%0d",
               got_cyc[0].size(), got_err[0].size(), exp_cyc[0].size(), exp_err[0].size());
    end
    for (int i = 0; i < exp_cyc[0].size() && i < got_cyc[0].size(); i++) begin
      checks++;
      if (got_cyc[0][i] !== exp_cyc[0][i] || got_dat[0][i] !== exp_dat[0][i]) begin
        errors++;
        $display("FAIL unmap_read%0d got cyc=%0d data=%h required cyc=%0d data=%h",
                 i, got_cyc[0][i], got_dat[0][i], exp_cyc[0][i], exp_dat[0][i]);
      end
    end
    for (int i = 0; i < exp_err[0].size() && i < got_err[0].size(); i++) begin
      checks++;
      if (got_err[0][i] !== exp_err[0][i]) begin
        errors++;
        $display("FAIL unmap_err%0d got cyc=%0d required cyc=%0d", i, got_err[0][i], exp_err[0][i]);
      end
    end
    clear_q(0);
  endtask

  task automatic test_random();
    int st;
    int r, k, sel;
    logic [31:0] a;
    for (int d = 0; d < ND; d++) begin
      for (int rr = 0; rr < 4; rr++) begin
        for (int kk = 0; kk < 9; kk++) begin
          a = rbase[rr] + ((kk < 8) ? 32'(4 * kk) : rsize[rr] - 32'd4);
          do_op(d, 1'b0, 1'b1, a, 4'hF, $urandom, st);
        end
      end
      for (int n = 0; n < 40; n++) begin
        r = $urandom_range(0, 3);
        k = $urandom_range(0, 8);
        a = rbase[r] + ((k < 8) ? 32'(4 * k) : rsize[r] - 32'd4) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) a = 32'h4000_0000 + 32'(4 * k);
        sel = $urandom_range(0, 9);
        do_op(d, sel < 6 || sel == 9, sel >= 5, a, 4'($urandom_range(0, 15)), $urandom, st);
      end
      settle();
      checks++;
      if (got_cyc[d].size() != exp_cyc[d].size() || got_err[d].size() != exp_err[d].size()) begin
        errors++;
        $display("FAIL rand_counts dut%0d got rv=%0d err=%0d required rv=%0d err=%0d", d,
                 got_cyc[d].size(), got_err[d].size(), exp_cyc[d].size(), exp_err[d].size());
      end
      for (int i = 0; i < exp_cyc[d].size() && i < got_cyc[d].size(); i++) begin
        checks++;
        if (got_cyc[d][i] !== exp_cyc[d][i] || got_dat[d][i] !== exp_dat[d][i]) begin
          errors++;
          $display("FAIL rand_read dut%0d #%0d got cyc=%0d data=%h required cyc=%0d data=%h",
                   d, i, got_cyc[d][i], got_dat[d][i], exp_cyc[d][i], exp_dat[d][i]);
        end
      end
      for (int i = 0; i < exp_err[d].size() && i < got_err[d].size(); i++) begin
        checks++;
        if (got_err[d][i] !== exp_err[d][i]) begin
          errors++;
          $display("FAIL rand_err dut%0d #%0d got cyc=%0d required cyc=%0d",
                   d, i, got_err[d][i], exp_err[d][i]);
        end
      end
      clear_q(d);
    end
  endtask

  task automatic test_reset_midflight();
    int st;
    do_op(2, 1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0, st);
    idle_all();
    exp_cyc[2].delete();
    exp_dat[2].delete();
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (wrq[d] !== 1'b1 || rv[d] !== 1'b0 || er[d] !== 1'b0 || rdat[d] !== 32'h0) begin
          errors++;
          $display("FAIL midreset_state dut%0d got wrq=%b rv=%b err=%b rdata=%h required 1 0 0 00000000",
                   d, wrq[d], rv[d], er[d], rdat[d]);
        end
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    settle();
    checks++;
    if (got_cyc[2].size() != 0) begin
      errors++;
      $display("FAIL midreset_discard got %0d readdatavalid pulses required 0", got_cyc[2].size());
    end
    clear_q(2);
    do_op(2, 1'b1, 1'b0, 32'h0000_0004, 4'hF, 32'h0, st);
    settle();
    checks++;
    if (got_cyc[2].size() != 1 || exp_cyc[2].size() != 1 ||
        got_cyc[2][0] !== exp_cyc[2][0] || got_dat[2][0] !== exp_dat[2][0]) begin
      errors++;
      $display("FAIL midreset_after got %0d pulses first cyc=%0d data=%h required 1 pulse cyc=%0d data=%h",
               got_cyc[2].size(), (got_cyc[2].size() > 0) ? got_cyc[2][0] : -1,
               (got_dat[2].size() > 0) ? got_dat[2][0] : 32'h0, exp_cyc[2][0], exp_dat[2][0]);
    end
    clear_q(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_pipeline();
    test_unmapped();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
